fetch_queue_stage: RTL and testbench

Parametrised instruction-fetch front end. It owns the program counter, issues pipelined requests to a fixed-latency synchronous instruction memory, and buffers returned words in a DEPTH-entry FIFO. The FIFO feeds decode over a valid/ready handshake. Redirects from execute flush the queue and discard stale in-flight responses using an epoch tag, replacing the single-register, stall-only fetch stage.

---
 rtl/fetch_queue_stage.sv | 134 +++++++++++++
 tb/tb_fetch_queue_stage.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_stage.sv
// fetch_queue_stage: instruction-fetch front end.
//   Owns the PC and issues one request per cycle to a synchronous instruction
//   memory with a fixed one-cycle latency. Returned words land in a DEPTH-entry
//   FIFO that feeds decode over a valid/ready handshake. A redirect flushes the
//   FIFO and bumps an epoch tag, so the response to a request already in flight
//   is recognised as stale and dropped.
// Ports:
//   clock, reset          clock, synchronous active-high reset
//   redirect_valid/pc     redirect from execute (overrides everything but reset)
//   imem_req_valid/addr   request this cycle, address = current PC
//   imem_resp_data        word for the request issued in the previous cycle
//   out_valid/ready       handshake to decode
//   out_pc/epoch/instr.   head entry of the FIFO
//   occupancy             registered FIFO entry count
module fetch_queue_stage #(
  parameter int              XLEN       = 32,
  parameter int              INST_WIDTH = 32,
  parameter int              DEPTH      = 4,
  parameter int              EPOCH_BITS = 2,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       imem_req_valid,
  output logic [XLEN-1:0]            imem_req_addr,
  input  logic [INST_WIDTH-1:0]      imem_resp_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [EPOCH_BITS-1:0]      out_epoch,
  output logic [INST_WIDTH-1:0]      out_instruction,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [EPOCH_BITS-1:0] epoch;
    logic [INST_WIDTH-1:0] inst;
  } entry_t;

  logic [XLEN-1:0]       pc_q, pc_d;
  logic [EPOCH_BITS-1:0] epoch_q, epoch_d;
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  inflight_q, inflight_d;
  logic [XLEN-1:0]       tag_pc_q, tag_pc_d;
  logic [EPOCH_BITS-1:0] tag_epoch_q, tag_epoch_d;
  entry_t [DEPTH-1:0]    fifo_q, fifo_d;

  logic [CNT_W:0] credits_used;
  logic           issue, push, pop;

  // Credits: an in-flight request has a FIFO slot reserved, so the FIFO can
  // never overflow even though memory cannot be back-pressured.
  assign credits_used = {1'b0, count_q} + (CNT_W+1)'(inflight_q);
  assign issue        = !reset && !redirect_valid && (credits_used < (CNT_W+1)'(DEPTH));

  // Responses tagged with an old epoch belong to a redirected-away stream.
  assign push = inflight_q && (tag_epoch_q == epoch_q) && !redirect_valid;
  assign pop  = out_valid && out_ready;

  assign imem_req_valid  = issue;
  assign imem_req_addr   = pc_q;
  assign out_valid       = !reset && !redirect_valid && (count_q != '0);
  assign out_pc          = fifo_q[head_q].pc;
  assign out_epoch       = fifo_q[head_q].epoch;
  assign out_instruction = fifo_q[head_q].inst;
  assign occupancy       = count_q;

  always_comb begin
    pc_d        = pc_q;
    epoch_d     = epoch_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    fifo_d      = fifo_q;
    inflight_d  = issue;
    tag_pc_d    = pc_q;
    tag_epoch_d = epoch_q;

    if (redirect_valid) begin
      pc_d    = redirect_pc;
      epoch_d = epoch_q + EPOCH_BITS'(1);
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (issue) pc_d = pc_q + XLEN'(INST_WIDTH/8);
      if (push) begin
        fifo_d[tail_q] = '{pc: tag_pc_q, epoch: tag_epoch_q, inst: imem_resp_data};
        tail_d         = tail_q + PTR_W'(1);
      end
      if (pop) head_d = head_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      epoch_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      inflight_q  <= 1'b0;
      tag_pc_q    <= '0;
      tag_epoch_q <= '0;
    end else begin
      pc_q        <= pc_d;
      epoch_q     <= epoch_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      inflight_q  <= inflight_d;
      tag_pc_q    <= tag_pc_d;
      tag_epoch_q <= tag_epoch_d;
    end
  end

  // Entry storage needs no reset; count/pointers qualify it.
  always_ff @(posedge clock) begin
    fifo_q <= fifo_d;
  end

endmodule

// File: tb/tb_fetch_queue_stage.sv
module tb_fetch_queue_stage;

  localparam logic [31:0] KEY = 32'hA5A50000;

  logic        clock = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic [31:0] imem_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [1:0]  out_epoch;
  logic [31:0] out_instruction;
  logic [2:0]  occupancy;

  fetch_queue_stage dut (
    .clock(clock), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_resp_data(imem_resp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_epoch(out_epoch), .out_instruction(out_instruction),
    .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  // One-cycle-latency memory: word = addr ^ KEY.
  always @(posedge clock) imem_resp_data <= imem_req_addr ^ KEY;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  epoch;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic expect_stream(input logic [31:0] start, input int n, input logic [1:0] ep);
    logic [31:0] a;
    sb.delete();
    a = start;
    for (int i = 0; i < n; i++) begin
      sb.push_back('{pc: a, epoch: ep});
      a = a + 32'd4;
    end
  endtask

  // Delivered entries are popped against the scoreboard; beyond the expected
  // prefix the stream simply continues and is not checked.
  always @(negedge clock) begin
    if (out_valid && out_ready && sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("out_pc", 64'(out_pc), 64'(e.pc));
      chk("out_instruction", 64'(out_instruction), 64'(e.pc ^ KEY));
      chk("out_epoch", 64'(out_epoch), 64'(e.epoch));
    end
  end

  initial begin
    int nreq;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    sb.delete();

    // Reset release, free-running stream.
    step(2);
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    expect_stream(32'h0, 8, 2'd0);
    reset = 1'b0; #1;
    chk("c0_req_valid", 64'(imem_req_valid), 64'd1);
    chk("c0_req_addr", 64'(imem_req_addr), 64'h0);
    step();
    chk("c1_out_valid", 64'(out_valid), 64'd0);
    chk("c1_req_addr", 64'(imem_req_addr), 64'h4);
    step();
    chk("c2_out_valid", 64'(out_valid), 64'd1);
    step(8);
    chk("stream_drained", 64'(sb.size()), 64'd0);

    // Back-pressure from reset: exactly DEPTH requests.
    reset = 1'b1; out_ready = 1'b0; sb.delete();
    step();
    reset = 1'b0; #1;
    nreq = 0;
    for (int i = 0; i < 8; i++) begin
      if (imem_req_valid) nreq++;
      step();
    end
    chk("bp_req_count", 64'(nreq), 64'd4);
    chk("bp_occupancy", 64'(occupancy), 64'd4);
    chk("bp_req_valid", 64'(imem_req_valid), 64'd0);
    chk("bp_hold_pc", 64'(out_pc), 64'h0);
    chk("bp_hold_inst", 64'(out_instruction), 64'(32'h0 ^ KEY));
    expect_stream(32'h0, 6, 2'd0);
    out_ready = 1'b1; #1;
    chk("bp_full_no_req", 64'(imem_req_valid), 64'd0);
    step();
    chk("bp_resume_valid", 64'(imem_req_valid), 64'd1);
    chk("bp_resume_addr", 64'(imem_req_addr), 64'h10);
    step(10);
    chk("bp_drained", 64'(sb.size()), 64'd0);

    // Redirect with 3 queued + 1 in flight.
    reset = 1'b1; out_ready = 1'b0; sb.delete();
    step();
    reset = 1'b0;
    step(4);
    chk("rd_occ_before", 64'(occupancy), 64'd3);
    redirect_valid = 1'b1; redirect_pc = 32'h100; out_ready = 1'b1;
    expect_stream(32'h100, 4, 2'd1);
    #1;
    chk("rd_out_valid", 64'(out_valid), 64'd0);
    chk("rd_req_valid", 64'(imem_req_valid), 64'd0);
    step();
    redirect_valid = 1'b0; #1;
    chk("rd_occ_after", 64'(occupancy), 64'd0);
    chk("rd_req_valid2", 64'(imem_req_valid), 64'd1);
    chk("rd_req_addr", 64'(imem_req_addr), 64'h100);
    step(8);
    chk("rd_drained", 64'(sb.size()), 64'd0);

    // Back-to-back redirects 0x200 then 0x300; epoch 1 -> 3.
    redirect_valid = 1'b1; redirect_pc = 32'h200; sb.delete();
    step();
    redirect_pc = 32'h300;
    expect_stream(32'h300, 4, 2'd3);
    #1;
    chk("rr_req_valid", 64'(imem_req_valid), 64'd0);
    step();
    redirect_valid = 1'b0; #1;
    chk("rr_req_addr", 64'(imem_req_addr), 64'h300);
    step(8);
    chk("rr_drained", 64'(sb.size()), 64'd0);

    // Fourth redirect since reset: epoch wraps to 0.
    redirect_valid = 1'b1; redirect_pc = 32'h400;
    expect_stream(32'h400, 3, 2'd0);
    step();
    redirect_valid = 1'b0;
    step(6);
    chk("wrap_drained", 64'(sb.size()), 64'd0);

    // PC wrap at the top of the address space.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    expect_stream(32'hFFFF_FFFC, 3, 2'd1);
    step();
    redirect_valid = 1'b0;
    step(6);
    chk("pcwrap_drained", 64'(sb.size()), 64'd0);

    // Reset in the middle of a running stream.
    reset = 1'b1; sb.delete(); #1;
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    chk("mrst_req_valid", 64'(imem_req_valid), 64'd0);
    step();
    reset = 1'b0;
    expect_stream(32'h0, 3, 2'd0);
    #1;
    chk("mrst_occupancy", 64'(occupancy), 64'd0);
    chk("mrst_req_valid2", 64'(imem_req_valid), 64'd1);
    chk("mrst_req_addr", 64'(imem_req_addr), 64'h0);
    step(6);
    chk("mrst_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
